lcd_text_writer: RTL
====================

// Module: lcd_text_writer
// PURPOSE
// - Downstream of LCD init: once init_ready is high, repaints a 2x16 HD44780 screen (4-bit mode).
// - Reads 32 chars from a char buffer; emits DDRAM-address and data nibbles to the shared lcd_transfer engine.
// - One frame = set line1 addr, 16 chars, set line2 addr, 16 chars (68 nibble transfers).
// PARAMETERS
// - CLK_FREQ  50_000_000  clock frequency, Hz; T1US = CLK_FREQ/1_000_000
// - COLS      16          chars per line; total chars = 2*COLS
// - DELAY_W   21          width of cmd_delay
// PORTS
// - CLK          in   1        clock, rising edge
// - RESET        in   1        asynchronous, active-high reset
// - init_ready   in   1        level; init sequence complete
// - refresh_req  in   1        pulse; request full-screen repaint
// - char_addr    out  5        buffer read address (0..31; 0-15 line1, 16-31 line2)
// - char_data    in   8        buffer read data; valid 1 cycle after char_addr
// - cmd_valid    out  1        nibble request to transfer engine
// - cmd_data     out  5        [4]=RS, [3:0]=nibble
// - cmd_delay    out  DELAY_W  post-nibble wait, cycles
// - cmd_done     in   1        1-cycle pulse; current nibble and delay finished
// - busy         out  1        frame in progress
// - frame_done   out  1        1-cycle pulse after last nibble of a frame
// BEHAVIOUR
// - Reset: state IDLE; cmd_valid=0, cmd_data=0, cmd_delay=0, char_addr=0, busy=0, frame_done=0, pending=0.
// - All outputs registered.
// - Handshake: cmd_valid held with stable cmd_data/cmd_delay until cmd_done.
//   Cycle after cmd_done: cmd_valid=0. Next nibble presented the cycle after that.
//   cmd_done while cmd_valid=0 is ignored.
// - Delays: high nibble T1US*10; low nibble T1US*53.
// - States:
//   - IDLE -> ADDR_HI when init_ready & (pending | refresh_req).
//     First frame starts automatically: pending is set on the init_ready rising edge.
//   - ADDR_HI: RS=0, nibble 4'h8 (line1) / 4'hC (line2) -> ADDR_LO.
//   - ADDR_LO: RS=0, nibble 4'h0 -> FETCH.
//   - FETCH: drive char_addr; wait 1 cycle; latch char_data -> CHAR_HI.
//   - CHAR_HI: RS=1, char[7:4] -> CHAR_LO.
//   - CHAR_LO: RS=1, char[3:0]; char_addr++ ->
//     - ADDR_HI if addr wrapped COLS-1 -> COLS;
//     - DONE if it was 2*COLS-1;
//     - else FETCH.
//   - DONE: frame_done=1 for 1 cycle, char_addr=0 -> IDLE.
// - refresh_req while busy sets pending. Multiple requests collapse to one extra frame. Never restarts mid-frame.
// - refresh_req in the same cycle as frame_done: pending set, next frame follows.
// - init_ready falling while busy: finish current nibble (await cmd_done), then IDLE.
//   pending cleared, no frame_done.
// - RESET mid-frame: immediate return to reset values. Transfer engine is reset by the same RESET.
// - busy=1 from leaving IDLE until DONE exits.
// STRUCTURE
// - Shared package lcd_pkg:
//   - RS bit position;
//   - DDRAM line base constants 8'h80/8'hC0;
//   - delay constants T10US/T53US;
//   - writer state enum.
// - No sub-module. Timing stays in the transfer engine; this block only sequences nibbles.
// TESTING
// - After reset, init_ready=1, buffer "HELLO..." -> first nibbles 0x08,0x00,0x14,0x18.
//   Delays 500/2650 cycles at 50 MHz.
// - Full frame with cmd_done 3 cycles after each cmd_valid -> 68 nibbles.
//   Nibble 35 = 0x0C (line2 addr); frame_done once; busy low after.
// - refresh_req x3 mid-frame -> exactly one additional frame, then IDLE.
// - init_ready dropped during CHAR_HI -> cmd_valid held until cmd_done, then IDLE; no frame_done.
// - RESET asserted mid-CHAR_LO -> next cycle cmd_valid=0, char_addr=0, busy=0.
//   Repaint restarts from ADDR_HI line1.
// - char_data 8'hA5 at addr 31 -> last nibbles 0x1A, 0x15; then frame_done.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared HD44780 constants and the text-writer state encoding for the LCD
// driver slice (init sequencer, transfer engine, text writer).
package lcd_pkg;

  localparam int RS_BIT = 4;

  localparam logic [7:0] DDRAM_LINE1 = 8'h80;
  localparam logic [7:0] DDRAM_LINE2 = 8'hC0;

  // Post-nibble waits in microseconds; converted to cycles by each user.
  localparam int T10US = 10;
  localparam int T53US = 53;

  typedef enum logic [2:0] {
    WR_IDLE    = 3'd0,
    WR_ADDR_HI = 3'd1,
    WR_ADDR_LO = 3'd2,
    WR_FETCH   = 3'd3,
    WR_CHAR_HI = 3'd4,
    WR_CHAR_LO = 3'd5,
    WR_DONE    = 3'd6
  } wr_state_e;

  function automatic int us_to_cycles(input int clk_freq, input int us);
    return (clk_freq / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/lcd_text_writer.sv
// Repaints a 2x16 HD44780 screen in 4-bit mode by sequencing DDRAM-address and
// character nibbles from a character buffer into the shared transfer engine.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int COLS     = 16,
  parameter int DELAY_W  = 21
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               init_ready,
  input  logic               refresh_req,
  output logic [4:0]         char_addr,
  input  logic [7:0]         char_data,
  output logic               cmd_valid,
  output logic [4:0]         cmd_data,
  output logic [DELAY_W-1:0] cmd_delay,
  input  logic               cmd_done,
  output logic               busy,
  output logic               frame_done,
  output logic [2:0]         dbg_state
);

  // Handshake: cmd_valid rises with cmd_data/cmd_delay and all three hold
  // steady until cmd_done is seen; the following cycle cmd_valid is low and
  // the next nibble is presented no earlier than the cycle after that.
  // cmd_done while cmd_valid is low is ignored.

  localparam logic [DELAY_W-1:0] DLY_HI    = DELAY_W'(us_to_cycles(CLK_FREQ, T10US));
  localparam logic [DELAY_W-1:0] DLY_LO    = DELAY_W'(us_to_cycles(CLK_FREQ, T53US));
  localparam logic [4:0]         COLS_A    = 5'(COLS);
  localparam logic [4:0]         LAST_COL  = 5'(COLS - 1);
  localparam logic [4:0]         LAST_CHAR = 5'(2 * COLS - 1);

  wr_state_e          state_q, state_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [4:0]         cmd_data_q, cmd_data_d;
  logic [DELAY_W-1:0] cmd_delay_q, cmd_delay_d;
  logic [4:0]         char_addr_q, char_addr_d;
  logic [7:0]         char_q, char_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               pending_q, pending_d;
  logic               init_q;
  logic               fetch_q, fetch_d;
  logic               abort_q, abort_d;

  logic               init_rise;
  logic               on_line2;
  logic               nib_state;
  logic               nib_rs;
  logic [3:0]         nib_val;
  logic [DELAY_W-1:0] nib_dly;
  wr_state_e          nib_next;
  logic               quit;

  assign init_rise = init_ready & ~init_q;
  assign on_line2  = (char_addr_q >= COLS_A);

  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_data_d   = cmd_data_q;
    cmd_delay_d  = cmd_delay_q;
    char_addr_d  = char_addr_q;
    char_d       = char_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pending_d    = pending_q | refresh_req | init_rise;
    fetch_d      = fetch_q;
    abort_d      = abort_q | (busy_q & ~init_ready);
    nib_state    = 1'b0;
    nib_rs       = 1'b0;
    nib_val      = 4'h0;
    nib_dly      = DLY_HI;
    nib_next     = state_q;
    quit         = 1'b0;

    case (state_q)
      WR_IDLE: begin
        if (init_ready && (pending_q || refresh_req)) begin
          state_d   = WR_ADDR_HI;
          busy_d    = 1'b1;
          pending_d = 1'b0;
        end
      end
      WR_ADDR_HI: begin
        nib_state = 1'b1;
        nib_val   = on_line2 ? DDRAM_LINE2[7:4] : DDRAM_LINE1[7:4];
        nib_next  = WR_ADDR_LO;
      end
      WR_ADDR_LO: begin
        nib_state = 1'b1;
        nib_val   = on_line2 ? DDRAM_LINE2[3:0] : DDRAM_LINE1[3:0];
        nib_dly   = DLY_LO;
        nib_next  = WR_FETCH;
      end
      WR_FETCH: begin
        // char_addr has been stable for a cycle by the time fetch_q is set,
        // so the buffer's registered read data is valid on the second cycle.
        if (abort_d) begin
          quit = 1'b1;
        end else if (!fetch_q) begin
          fetch_d = 1'b1;
        end else begin
          fetch_d = 1'b0;
          char_d  = char_data;
          state_d = WR_CHAR_HI;
        end
      end
      WR_CHAR_HI: begin
        nib_state = 1'b1;
        nib_rs    = 1'b1;
        nib_val   = char_q[7:4];
        nib_next  = WR_CHAR_LO;
      end
      WR_CHAR_LO: begin
        nib_state = 1'b1;
        nib_rs    = 1'b1;
        nib_val   = char_q[3:0];
        nib_dly   = DLY_LO;
        if (char_addr_q == LAST_CHAR) begin
          nib_next = WR_DONE;
        end else if (char_addr_q == LAST_COL) begin
          nib_next = WR_ADDR_HI;
        end else begin
          nib_next = WR_FETCH;
        end
      end
      WR_DONE: begin
        state_d     = WR_IDLE;
        busy_d      = 1'b0;
        char_addr_d = 5'd0;
        abort_d     = 1'b0;
      end
      default: begin
        quit = 1'b1;
      end
    endcase

    if (nib_state) begin
      if (!cmd_valid_q) begin
        if (abort_d) begin
          quit = 1'b1;
        end else begin
          cmd_valid_d         = 1'b1;
          cmd_data_d          = {1'b0, nib_val};
          cmd_data_d[RS_BIT]  = nib_rs;
          cmd_delay_d         = nib_dly;
        end
      end else if (cmd_done) begin
        cmd_valid_d = 1'b0;
        if (abort_d) begin
          quit = 1'b1;
        end else begin
          state_d = nib_next;
          if (state_q == WR_CHAR_LO) begin
            char_addr_d = char_addr_q + 5'd1;
          end
          if (nib_next == WR_DONE) begin
            frame_done_d = 1'b1;
          end
        end
      end
    end

    // Losing init_ready abandons the frame silently once the bus is quiet.
    if (quit) begin
      state_d     = WR_IDLE;
      busy_d      = 1'b0;
      pending_d   = 1'b0;
      char_addr_d = 5'd0;
      abort_d     = 1'b0;
      fetch_d     = 1'b0;
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= WR_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_data_q   <= 5'd0;
      cmd_delay_q  <= '0;
      char_addr_q  <= 5'd0;
      char_q       <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
      init_q       <= 1'b0;
      fetch_q      <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_data_q   <= cmd_data_d;
      cmd_delay_q  <= cmd_delay_d;
      char_addr_q  <= char_addr_d;
      char_q       <= char_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
      init_q       <= init_ready;
      fetch_q      <= fetch_d;
      abort_q      <= abort_d;
    end
  end

  assign char_addr  = char_addr_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_data   = cmd_data_q;
  assign cmd_delay  = cmd_delay_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule
